// File: rtl/vga_frame_reader_if.sv
// vga_frame_reader_if
//   Read-only port B of the frame memory as seen by the VGA frame reader.
//   DataAdr_VGA : word address driven by the reader (master)
//   pixel       : low byte of the addressed word, one clk after the address
//   dimensiones : full addressed word; word 0 carries {W, H}
interface vga_frame_reader_if;
  logic [18:0] DataAdr_VGA;
  logic [7:0]  pixel;
  logic [15:0] dimensiones;

  modport master (
    output DataAdr_VGA,
    input  pixel,
    input  dimensiones
  );

  modport slave (
    input  DataAdr_VGA,
    output pixel,
    output dimensiones
  );
endinterface

// File: rtl/vga_frame_reader.sv
// vga_frame_reader
//   Generates VGA timing (640x480 by default) and streams a row-major
//   grayscale image from frame memory port B to the DAC pins. Word 0 holds
//   the image size {W, H}; pixel (x, y) lives at word 1 + y*W + x. The size
//   is re-read once per frame when the scan enters vertical blanking.
// Ports
//   clk, reset       : system clock, synchronous active-high reset
//   mem (master)     : DataAdr_VGA out, pixel / dimensiones in
//   vga_clk          : pixel enable, toggles every clk
//   vga_hs, vga_vs   : active-low syncs
//   vga_blank_n      : low outside the visible area
//   vga_r/g/b        : grayscale, all three equal
//   frame_start      : one-clk pulse while pixel (0,0) is on the pins
//   dims_valid       : image size has been latched since reset
module vga_frame_reader #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  vga_frame_reader_if.master         mem,
  output logic                       vga_clk,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic                       vga_blank_n,
  output logic [7:0]                 vga_r,
  output logic [7:0]                 vga_g,
  output logic [7:0]                 vga_b,
  output logic                       frame_start,
  output logic                       dims_valid
);

  localparam logic [9:0] H_LAST_L   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST_L   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_L    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L    = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST_L = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST_L  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST_L = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST_L  = 10'(V_VIS + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIM_REQ = 2'd1,
    DIM_LAT = 2'd2,
    SCAN    = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;

  logic        tick_r;
  logic [9:0]  hc_r, vc_r;
  logic [9:0]  hc_nxt_s, vc_nxt_s;
  logic [18:0] ptr_r, ptr_nxt_s, ptr_base_s;
  logic [18:0] addr_r, addr_nxt_s;
  logic [7:0]  w_r, h_r, w_nxt_s, h_nxt_s;
  logic        dims_valid_r, dims_valid_nxt_s;

  logic        new_in_img_s;
  logic        cur_in_img_s;
  logic        cur_visible_s;
  logic        vblank_hit_s;
  logic        frame_top_s;

  logic        hs_r, vs_r, blank_n_r, frame_start_r;
  logic [7:0]  rgb_r;

  // Raster position the counters will move to on the next tick
  always_comb begin
    hc_nxt_s = hc_r;
    vc_nxt_s = vc_r;
    if (hc_r == H_LAST_L) begin
      hc_nxt_s = 10'd0;
      if (vc_r == V_LAST_L) begin
        vc_nxt_s = 10'd0;
      end else begin
        vc_nxt_s = vc_r + 10'd1;
      end
    end else begin
      hc_nxt_s = hc_r + 10'd1;
    end
  end

  // Region decodes for the current and the upcoming position
  always_comb begin
    // Fetch decisions look at the position being entered, display decisions
    // at the position currently held (its data is already in flight).
    new_in_img_s  = dims_valid_r && (hc_nxt_s < {2'b00, w_r}) && (vc_nxt_s < {2'b00, h_r});
    cur_in_img_s  = dims_valid_r && (hc_r < {2'b00, w_r}) && (vc_r < {2'b00, h_r});
    cur_visible_s = (hc_r < H_VIS_L) && (vc_r < V_VIS_L);
    vblank_hit_s  = tick_r && (hc_nxt_s == 10'd0) && (vc_nxt_s == V_VIS_L);
    frame_top_s   = (hc_nxt_s == 10'd0) && (vc_nxt_s == 10'd0);
  end

  // Fetch FSM: next state, address, word pointer and latched image size
  always_comb begin
    state_nxt_s      = state_r;
    addr_nxt_s       = addr_r;
    ptr_nxt_s        = ptr_r;
    w_nxt_s          = w_r;
    h_nxt_s          = h_r;
    dims_valid_nxt_s = dims_valid_r;
    // Entering (0,0) restarts the image at word 1 on that very tick.
    ptr_base_s       = frame_top_s ? 19'd1 : ptr_r;
    case (state_r)
      IDLE: begin
        addr_nxt_s = 19'd0;
        if (vblank_hit_s) begin
          state_nxt_s = DIM_REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DIM_REQ: begin
        addr_nxt_s  = 19'd0;
        state_nxt_s = DIM_LAT;
      end
      DIM_LAT: begin
        // Word 0 has been on the bus for one clk by now.
        w_nxt_s          = mem.dimensiones[15:8];
        h_nxt_s          = mem.dimensiones[7:0];
        dims_valid_nxt_s = 1'b1;
        state_nxt_s      = SCAN;
      end
      SCAN: begin
        if (vblank_hit_s) begin
          addr_nxt_s  = 19'd0;
          state_nxt_s = DIM_REQ;
        end else if (tick_r) begin
          if (new_in_img_s) begin
            addr_nxt_s = ptr_base_s;
            ptr_nxt_s  = ptr_base_s + 19'd1;
          end else begin
            ptr_nxt_s  = ptr_base_s;
          end
        end else begin
          ptr_nxt_s = ptr_r;
        end
      end
      default: begin
        addr_nxt_s  = 19'd0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pixel-rate divider, raster counters and fetch datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_r       <= 1'b0;
      hc_r         <= 10'd0;
      vc_r         <= 10'd0;
      ptr_r        <= 19'd1;
      addr_r       <= 19'd0;
      w_r          <= 8'd0;
      h_r          <= 8'd0;
      dims_valid_r <= 1'b0;
    end else begin
      tick_r       <= ~tick_r;
      ptr_r        <= ptr_nxt_s;
      addr_r       <= addr_nxt_s;
      w_r          <= w_nxt_s;
      h_r          <= h_nxt_s;
      dims_valid_r <= dims_valid_nxt_s;
      if (tick_r) begin
        hc_r <= hc_nxt_s;
        vc_r <= vc_nxt_s;
      end
    end
  end

  // Output stage: one pixel behind the counters so the fetched byte lines up
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      blank_n_r     <= 1'b0;
      rgb_r         <= 8'd0;
      frame_start_r <= 1'b0;
    end else if (tick_r) begin
      hs_r          <= ~((hc_r >= HS_FIRST_L) && (hc_r <= HS_LAST_L));
      vs_r          <= ~((vc_r >= VS_FIRST_L) && (vc_r <= VS_LAST_L));
      blank_n_r     <= cur_visible_s;
      // The byte for the held position was addressed on the previous tick.
      rgb_r         <= (cur_in_img_s && cur_visible_s) ? mem.pixel : 8'd0;
      frame_start_r <= (hc_r == 10'd0) && (vc_r == 10'd0);
    end else begin
      frame_start_r <= 1'b0;
    end
  end

  assign mem.DataAdr_VGA = addr_r;
  assign vga_clk         = tick_r;
  assign vga_hs          = hs_r;
  assign vga_vs          = vs_r;
  assign vga_blank_n     = blank_n_r;
  assign vga_r           = rgb_r;
  assign vga_g           = rgb_r;
  assign vga_b           = rgb_r;
  assign frame_start     = frame_start_r;
  assign dims_valid      = dims_valid_r;

endmodule
